// File: rtl/coeff_idx_tracker.sv
// Per-coefficient greater-1/greater-2 budget tracker for one CG in reverse scan order.
// Optional CABAC_IDX_TRACK_STATS_EN adds nonzero/escape beat counters.
module coeff_idx_tracker #(
  parameter int C1FLAG_NUMBER = 4,
  parameter int C2FLAG_NUMBER = 1,
  parameter int LEVEL_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [LEVEL_W-1:0] in_level_i,
  input  logic               in_first_i,
  input  logic               in_last_i,
  input  logic               in_tu_start_i,
  input  logic               in_luma_i,
  input  logic               in_cg_is_dc_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               out_sig_o,
  output logic [7:0]         out_c1Idx_o,
  output logic [7:0]         out_c2Idx_o,
  output logic [1:0]         out_c1_o,
  output logic [1:0]         out_ctx_set_o,
  output logic [7:0]         out_base_level_o,
  output logic               out_escape_o,
  output logic [LEVEL_W-1:0] out_rem_o,
  output logic               out_last_o
`ifdef CABAC_IDX_TRACK_STATS_EN
  ,
  output logic [31:0]        stat_nz_count_o,
  output logic [31:0]        stat_esc_count_o
`endif
);

  localparam logic [7:0] C1N = 8'(C1FLAG_NUMBER);
  localparam logic [7:0] C2N = 8'(C2FLAG_NUMBER);

  logic [7:0]         c1_idx_q, c1_idx_d, c2_idx_q, c2_idx_d;
  logic [1:0]         c1_q, c1_d, ctx_set_q, ctx_set_d;
  logic               prev_c1_zero_q, prev_c1_zero_d;
  logic [7:0]         c1_idx_e, c2_idx_e;
  logic [1:0]         c1_e;
  logic               sig, esc, gt1, in_budget, accept;
  logic [7:0]         base;
  logic [LEVEL_W-1:0] rem;
  logic               out_valid_q;

  assign in_ready_o  = !out_valid_q || out_ready_i;
  assign out_valid_o = out_valid_q;
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    // in_first overrides whatever the registers hold, which also recovers a missed in_last
    c1_idx_e  = in_first_i ? 8'd0 : c1_idx_q;
    c2_idx_e  = in_first_i ? 8'd0 : c2_idx_q;
    c1_e      = in_first_i ? 2'd1 : c1_q;
    ctx_set_d = in_first_i ? {!in_cg_is_dc_i && in_luma_i, !in_tu_start_i && prev_c1_zero_q}
                           : ctx_set_q;
    in_budget = c1_idx_e < C1N;
    base      = in_budget ? ((c2_idx_e < C2N) ? 8'd3 : 8'd2) : 8'd1;
    sig       = |in_level_i;
    gt1       = in_level_i > LEVEL_W'(1);
    esc       = sig && (in_level_i >= LEVEL_W'(base));
    rem       = esc ? (in_level_i - LEVEL_W'(base)) : '0;

    c1_idx_d = c1_idx_e;
    c2_idx_d = c2_idx_e;
    c1_d     = c1_e;
    if (sig) begin
      if (c1_idx_e != 8'hFF) c1_idx_d = c1_idx_e + 8'd1;
      if (in_budget && gt1) begin
        if (c2_idx_e != 8'hFF) c2_idx_d = c2_idx_e + 8'd1;
        c1_d = 2'd0;
      end else if (in_budget && (c1_e == 2'd1 || c1_e == 2'd2)) begin
        c1_d = c1_e + 2'd1;
      end
    end
    // A zero last beat leaves c1 as-is, so its effective value is carried over
    prev_c1_zero_d = in_last_i ? (c1_d == 2'd0) : prev_c1_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_idx_q       <= 8'd0;
      c2_idx_q       <= 8'd0;
      c1_q           <= 2'd1;
      ctx_set_q      <= 2'd0;
      prev_c1_zero_q <= 1'b0;
    end else if (accept) begin
      c1_idx_q       <= c1_idx_d;
      c2_idx_q       <= c2_idx_d;
      c1_q           <= c1_d;
      ctx_set_q      <= ctx_set_d;
      prev_c1_zero_q <= prev_c1_zero_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      out_sig_o        <= 1'b0;
      out_c1Idx_o      <= 8'd0;
      out_c2Idx_o      <= 8'd0;
      out_c1_o         <= 2'd0;
      out_ctx_set_o    <= 2'd0;
      out_base_level_o <= 8'd0;
      out_escape_o     <= 1'b0;
      out_rem_o        <= '0;
      out_last_o       <= 1'b0;
    end else if (accept) begin
      out_valid_q      <= 1'b1;
      out_sig_o        <= sig;
      out_c1Idx_o      <= c1_idx_e;
      out_c2Idx_o      <= c2_idx_e;
      out_c1_o         <= c1_e;
      out_ctx_set_o    <= ctx_set_d;
      out_base_level_o <= base;
      out_escape_o     <= esc;
      out_rem_o        <= rem;
      out_last_o       <= in_last_i;
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef CABAC_IDX_TRACK_STATS_EN
  logic [31:0] nz_cnt_q, esc_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_cnt_q  <= 32'd0;
      esc_cnt_q <= 32'd0;
    end else if (accept) begin
      nz_cnt_q  <= nz_cnt_q + {31'd0, sig};
      esc_cnt_q <= esc_cnt_q + {31'd0, esc};
    end
  end

  assign stat_nz_count_o  = nz_cnt_q;
  assign stat_esc_count_o = esc_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_coeff_idx_tracker.sv
// Bench for coeff_idx_tracker: directed vector table, backpressure/reset sequences,
// and a randomized run against a reference model.
module tb_coeff_idx_tracker;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_first, in_last, in_tu_start, in_luma, in_cg_is_dc;
  logic [15:0] in_level;
  logic        out_valid, out_ready, out_sig, out_escape, out_last;
  logic [7:0]  out_c1Idx, out_c2Idx, out_base_level;
  logic [1:0]  out_c1, out_ctx_set;
  logic [15:0] out_rem;
`ifdef CABAC_IDX_TRACK_STATS_EN
  logic [31:0] stat_nz, stat_esc;
`endif

  coeff_idx_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_level_i(in_level),
    .in_first_i(in_first), .in_last_i(in_last), .in_tu_start_i(in_tu_start),
    .in_luma_i(in_luma), .in_cg_is_dc_i(in_cg_is_dc),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_sig_o(out_sig),
    .out_c1Idx_o(out_c1Idx), .out_c2Idx_o(out_c2Idx), .out_c1_o(out_c1),
    .out_ctx_set_o(out_ctx_set), .out_base_level_o(out_base_level),
    .out_escape_o(out_escape), .out_rem_o(out_rem), .out_last_o(out_last)
`ifdef CABAC_IDX_TRACK_STATS_EN
    , .stat_nz_count_o(stat_nz), .stat_esc_count_o(stat_esc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lvl;
    logic        f, l, tu, lu, dc;
    logic [63:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  function automatic logic [63:0] pk(input logic sg, input logic [7:0] c1i, input logic [7:0] c2i,
                                     input logic [1:0] c1, input logic [1:0] ctx, input logic [7:0] base,
                                     input logic esc, input logic [15:0] rem, input logic lst);
    return {17'd0, sg, c1i, c2i, c1, ctx, base, esc, rem, lst};
  endfunction

  function automatic logic [63:0] dut_out();
    return pk(out_sig, out_c1Idx, out_c2Idx, out_c1, out_ctx_set, out_base_level,
              out_escape, out_rem, out_last);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int lvl, input bit f, input bit l, input bit tu, input bit lu,
                              input bit dc, input bit sg, input int c1i, input int c2i, input int c1,
                              input int ctx, input int base, input bit esc, input int rem);
    vec_t v;
    v.lvl = 16'(lvl); v.f = f; v.l = l; v.tu = tu; v.lu = lu; v.dc = dc;
    v.exp = pk(sg, 8'(c1i), 8'(c2i), 2'(c1), 2'(ctx), 8'(base), esc, 16'(rem), l);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_valid = 1'b1; in_level = v.lvl; in_first = v.f; in_last = v.l;
    in_tu_start = v.tu; in_luma = v.lu; in_cg_is_dc = v.dc;
  endtask

  // Reference model: budget counters derived directly from the coding rules
  int m_c1i, m_c2i, m_c1, m_ctx, m_prev, m_nz, m_esc;

  task automatic model_reset();
    m_c1i = 0; m_c2i = 0; m_c1 = 1; m_ctx = 0; m_prev = 0; m_nz = 0; m_esc = 0;
  endtask

  task automatic model_beat(output logic [63:0] exp);
    int lv, base, rem;
    bit budget, sg, es;
    lv = int'(in_level);
    if (in_first) begin
      m_c1i = 0; m_c2i = 0; m_c1 = 1;
      m_ctx = ((!in_cg_is_dc && in_luma) ? 2 : 0) + ((!in_tu_start && m_prev != 0) ? 1 : 0);
    end
    budget = m_c1i < 4;
    base   = budget ? ((m_c2i < 1) ? 3 : 2) : 1;
    sg     = lv != 0;
    es     = sg && lv >= base;
    rem    = es ? lv - base : 0;
    exp = pk(sg, 8'(m_c1i), 8'(m_c2i), 2'(m_c1), 2'(m_ctx), 8'(base), es, 16'(rem), in_last);
    if (sg) begin
      m_c1i = (m_c1i < 255) ? m_c1i + 1 : 255;
      if (budget && lv > 1) begin
        m_c2i = (m_c2i < 255) ? m_c2i + 1 : 255;
        m_c1  = 0;
      end else if (budget && (m_c1 == 1 || m_c1 == 2)) begin
        m_c1 = m_c1 + 1;
      end
    end
    if (in_last) m_prev = (m_c1 == 0) ? 1 : 0;
    m_nz  += sg ? 1 : 0;
    m_esc += es ? 1 : 0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_level = '0; in_first = 1'b0; in_last = 1'b0;
    in_tu_start = 1'b0; in_luma = 1'b0; in_cg_is_dc = 1'b0;
  endtask

  vec_t tbl[17];
  vec_t x, y;
  logic [63:0] exp;
  logic [63:0] q[$];

  initial begin
    // lvl f l tu lu dc | sig c1i c2i c1 ctx base esc rem
    tbl[0]  = mk(3,     1,0, 1,1,0, 1,0,0,1,2,3,1,0);
    tbl[1]  = mk(1,     0,0, 1,0,1, 1,1,1,0,2,2,0,0);
    tbl[2]  = mk(2,     0,0, 1,0,1, 1,2,1,0,2,2,1,0);
    tbl[3]  = mk(1,     0,0, 1,0,1, 1,3,2,0,2,2,0,0);
    tbl[4]  = mk(1,     0,1, 1,0,1, 1,4,2,0,2,1,1,0);
    tbl[5]  = mk(2,     1,1, 0,1,0, 1,0,0,1,3,3,0,0);
    tbl[6]  = mk(2,     1,1, 0,0,1, 1,0,0,1,1,3,0,0);
    tbl[7]  = mk(1,     1,0, 1,1,0, 1,0,0,1,2,3,0,0);
    tbl[8]  = mk(1,     0,0, 1,0,1, 1,1,0,2,2,3,0,0);
    tbl[9]  = mk(1,     0,0, 1,0,1, 1,2,0,3,2,3,0,0);
    tbl[10] = mk(1,     0,1, 1,0,1, 1,3,0,3,2,3,0,0);
    tbl[11] = mk(2,     1,0, 0,0,0, 1,0,0,1,0,3,0,0);
    tbl[12] = mk(0,     0,0, 1,0,1, 0,1,1,0,0,2,0,0);
    tbl[13] = mk(5,     0,1, 1,0,1, 1,1,1,0,0,2,1,3);
    tbl[14] = mk(0,     1,1, 0,1,1, 0,0,0,1,1,3,0,0);
    tbl[15] = mk(65535, 1,1, 0,1,0, 1,0,0,1,2,3,1,65532);
    tbl[16] = mk(1,     0,0, 1,0,1, 1,1,1,0,2,2,0,0);

    idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_fields", dut_out(), 64'd0);
    chk("rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
`ifdef CABAC_IDX_TRACK_STATS_EN
      if (i == 4) begin
        chk("stat_nz_cg1", {32'd0, stat_nz}, 64'd5);
        chk("stat_esc_cg1", {32'd0, stat_esc}, 64'd3);
      end
`endif
    end

    // Backpressure: hold Y at the input for 3 stalled cycles behind X
    x = mk(1, 1,0, 1,1,0, 1,0,0,1,2,3,0,0);
    y = mk(3, 0,1, 0,0,1, 1,1,0,2,2,3,1,0);
    @(negedge clk); drive(x);
    @(posedge clk); #1;
    chk("bp_x", dut_out(), x.exp);
    @(negedge clk); drive(y); out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_hold", {dut_out()[62:0], out_valid}, {x.exp[62:0], 1'b1});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_ready_high", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("bp_y", dut_out(), y.exp);
    @(negedge clk); idle();
    @(posedge clk); #1;
    chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // Reset mid-CG with a beat sitting in the output register
    @(negedge clk); drive(mk(2, 1,1, 1,1,0, 0,0,0,0,0,0,0,0));
    @(negedge clk); drive(mk(3, 0,0, 0,0,0, 0,0,0,0,0,0,0,0));
    @(negedge clk); idle(); out_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_fields", dut_out(), 64'd0);
`ifdef CABAC_IDX_TRACK_STATS_EN
    chk("midrst_stats", {stat_nz, stat_esc}, 64'd0);
`endif
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    x = mk(1, 0,0, 1,1,0, 1,0,0,1,0,3,0,0);
    y = mk(1, 1,1, 0,0,0, 1,0,0,1,0,3,0,0);
    drive(x);
    @(posedge clk); #1;
    chk("postrst_nofirst", dut_out(), x.exp);
    @(negedge clk); drive(y);
    @(posedge clk); #1;
    chk("postrst_prev_zero", dut_out(), y.exp);

    // Randomized run against the reference model
    @(negedge clk); idle(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk);
      in_valid = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 3)       in_level = 16'd0;
      else if (r < 6)  in_level = 16'd1;
      else if (r < 8)  in_level = 16'd2;
      else if (r == 8) in_level = 16'($urandom_range(3, 20));
      else             in_level = 16'($urandom_range(0, 65535));
      in_first    = ($urandom_range(0, 4) == 0);
      in_last     = ($urandom_range(0, 4) == 0);
      in_tu_start = $urandom_range(0, 1) != 0;
      in_luma     = $urandom_range(0, 1) != 0;
      in_cg_is_dc = $urandom_range(0, 1) != 0;
      out_ready   = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      chk("rnd_in_ready", {63'd0, in_ready}, {63'd0, (q.size() == 0) || out_ready});
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_unexpected_beat", dut_out(), 64'd0 - 64'd1);
        else               chk("rnd_beat", dut_out(), q.pop_front());
      end
      if (in_valid && in_ready) begin
        model_beat(exp);
        q.push_back(exp);
      end
    end
    @(negedge clk); idle(); out_ready = 1'b1;
    #1;
    if (out_valid && q.size() != 0) chk("rnd_drain", dut_out(), q.pop_front());
    @(posedge clk); #1;
    chk("rnd_empty", {63'd0, out_valid}, 64'd0);
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);
`ifdef CABAC_IDX_TRACK_STATS_EN
    chk("rnd_stat_nz", {32'd0, stat_nz}, 64'(m_nz));
    chk("rnd_stat_esc", {32'd0, stat_esc}, 64'(m_esc));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
